fifo_sample_reader: RTL and testbench
=====================================

FIFO_SAMPLE_READER -- requirements
Module: fifo_sample_reader

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 16, sample width; signed two's complement; same value as the generator/FIFO package.
REQ-002 SHALL have parameter: DIV_WIDTH, 16, width of the sample-period divider.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port: clk  in  1  rising-edge clock, sole clock domain.
REQ-005 SHALL have port: rst  in  1  asynchronous active-low reset.
REQ-006 SHALL have port: en_low_i  in  1  active-low run enable (0 = run).
REQ-007 SHALL have port: rate_i  in  DIV_WIDTH  output sample period, in clocks.
REQ-008 SHALL have port: empty_i  in  1  FIFO empty flag.
REQ-009 SHALL have port: data_i  in  DATA_WIDTH  FIFO read data; valid one cycle after rd_en_o.
REQ-010 SHALL have port: rd_en_o  out  1  FIFO pop strobe.
REQ-011 SHALL have port: sample_o  out  DATA_WIDTH  current output sample, signed.
REQ-012 SHALL have port: sample_valid_o  out  1  one-cycle pulse; sample_o updated.
REQ-013 SHALL have port: clr_underrun_i  in  1  synchronous clear of the underrun status.
REQ-014 SHALL have port: underrun_o  out  1  sticky underrun flag.
REQ-015 SHALL have port: underrun_cnt_o  out  8  saturating underrun count.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT_TICK, READ, CAPTURE; encoding 2 bits; the unused code SHALL return to IDLE.
REQ-017 SHALL, when leaving IDLE, latch rate_i into period register P; rate_i values below 3 SHALL latch as 3; rate_i changes while running SHALL be ignored.
REQ-018 SHALL run the divider counter 0..P-1 only outside IDLE; tick = (count == P-1); count SHALL wrap to 0 on tick and SHALL be held at 0 in IDLE.
REQ-019 SHALL, in IDLE: stay while en_low_i=1; go to WAIT_TICK when en_low_i=0.
REQ-020 SHALL, in WAIT_TICK on tick with empty_i=0, go to READ.
REQ-021 SHALL, in WAIT_TICK on tick with empty_i=1 (underrun): stay in WAIT_TICK; hold sample_o; pulse sample_valid_o; set underrun_o; increment underrun_cnt_o.
REQ-022 SHALL, in READ: assert rd_en_o for exactly one cycle, then go to CAPTURE.
REQ-023 SHALL, at the edge ending CAPTURE, load sample_o <= data_i, pulse sample_valid_o for one cycle, and go to WAIT_TICK.
REQ-024 SHALL give a latency of 3 clocks from tick to valid: tick in cycle T -> rd_en_o=1 in cycle T+1 -> sample_o/sample_valid_o updated in cycle T+3.
REQ-025 SHALL never assert rd_en_o while empty_i=1 at the tick that launched the read; rd_en_o SHALL be 0 outside READ.
REQ-026 SHALL, when en_low_i goes 1 in WAIT_TICK, go to IDLE on the next edge.
REQ-027 SHALL, when en_low_i goes 1 in READ or CAPTURE, finish the capture (popped data is never lost), then go to IDLE.
REQ-028 SHALL hold sample_o in IDLE, with sample_valid_o=0.
REQ-029 SHALL saturate underrun_cnt_o at 255.
REQ-030 SHALL have clr_underrun_i clear underrun_o and underrun_cnt_o to 0 on the next edge, with priority over a simultaneous underrun increment.
REQ-031 SHALL drive all outputs from flops except rd_en_o, which SHALL be decoded from state only, never from inputs.

Reset
REQ-032 SHALL, on rst=0, immediately (asynchronously) set: state=IDLE, count=0, P=3, rd_en_o=0, sample_o=0, sample_valid_o=0, underrun_o=0, underrun_cnt_o=0.
REQ-033 SHALL abandon an in-flight READ/CAPTURE on reset, with no sample_valid_o pulse.
REQ-034 SHALL leave IDLE no earlier than the first edge after rst deasserts, with en_low_i=0.

Verification
REQ-035 SHALL be verified by: rate_i=4, FIFO holds 0x0010,0x0020,0x0030, en_low_i=0 -> sample_o=0x0010,0x0020,0x0030 with sample_valid_o every 4 clks; rd_en_o exactly one cycle per sample.
REQ-036 SHALL be verified by: an empty FIFO at a tick after sample 0x0030 -> sample_o stays 0x0030, sample_valid_o pulses, underrun_o=1, underrun_cnt_o=1, rd_en_o=0.
REQ-037 SHALL be verified by: 300 consecutive underrun ticks -> underrun_cnt_o=255; clr_underrun_i=1 coincident with an underrun tick -> underrun_o=0, underrun_cnt_o=0.
REQ-038 SHALL be verified by: en_low_i=1 during READ -> CAPTURE completes, sample_o=popped value, then IDLE, rd_en_o=0 thereafter.
REQ-039 SHALL be verified by: rate_i=1 -> period 3 clocks; rate_i changed to 10 while running -> period unchanged until the next IDLE exit.
REQ-040 SHALL be verified by: rst=0 mid-CAPTURE -> all outputs 0 immediately; no valid pulse; formal: never (rd_en_o && state!=READ).

Source files
------------

// File: rtl/fifo_sample_reader.sv
// Paced FIFO reader: pops one sample every P clocks and presents it as a held output.
// An empty FIFO at a pacing tick is counted as an underrun, and the last sample is kept.
module fifo_sample_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_low_i,
  input  logic [DIV_WIDTH-1:0]  rate_i,
  input  logic                  empty_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  rd_en_o,
  output logic [DATA_WIDTH-1:0] sample_o,
  output logic                  sample_valid_o,
  input  logic                  clr_underrun_i,
  output logic                  underrun_o,
  output logic [7:0]            underrun_cnt_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    READ      = 2'd2,
    CAPTURE   = 2'd3
  } state_t;

  localparam logic [DIV_WIDTH-1:0] MIN_PERIOD = DIV_WIDTH'(3);

  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  count_q, count_d;
  logic [DIV_WIDTH-1:0]  period_q, period_d;
  logic [DATA_WIDTH-1:0] sample_q, sample_d;
  logic                  valid_q, valid_d;
  logic                  underrun_q, underrun_d;
  logic [7:0]            ucnt_q, ucnt_d;
  logic                  tick;
  logic                  underrun_evt;

  assign tick = (state_q != IDLE) && (count_q == (period_q - DIV_WIDTH'(1)));

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    period_d     = period_q;
    sample_d     = sample_q;
    valid_d      = 1'b0;
    underrun_d   = underrun_q;
    ucnt_d       = ucnt_q;
    underrun_evt = 1'b0;

    case (state_q)
      IDLE: begin
        if (!en_low_i) begin
          state_d  = WAIT_TICK;
          period_d = (rate_i < MIN_PERIOD) ? MIN_PERIOD : rate_i;
        end
      end
      WAIT_TICK: begin
        // Disabling wins over a coincident tick: no read is launched and no underrun is logged.
        if (en_low_i) begin
          state_d = IDLE;
        end else if (tick) begin
          if (empty_i) begin
            valid_d      = 1'b1;
            underrun_evt = 1'b1;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        sample_d = data_i;
        valid_d  = 1'b1;
        state_d  = en_low_i ? IDLE : WAIT_TICK;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_q == IDLE) || (state_d == IDLE) || tick) begin
      count_d = '0;
    end else begin
      count_d = count_q + DIV_WIDTH'(1);
    end

    if (clr_underrun_i) begin
      underrun_d = 1'b0;
      ucnt_d     = 8'd0;
    end else if (underrun_evt) begin
      underrun_d = 1'b1;
      if (ucnt_q != 8'hFF) begin
        ucnt_d = ucnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      period_q   <= MIN_PERIOD;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
      ucnt_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      period_q   <= period_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
      ucnt_q     <= ucnt_d;
    end
  end

  assign rd_en_o        = (state_q == READ);
  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign underrun_o     = underrun_q;
  assign underrun_cnt_o = ucnt_q;

endmodule

// File: tb/tb_fifo_sample_reader.sv
// Directed bench for fifo_sample_reader: table of expected samples plus hand-written
// sequences for underrun saturation/clear, disable during READ, and reset mid-capture.
module tb_fifo_sample_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_low_i = 1'b1;
  logic [15:0] rate_i = 16'd4;
  logic        empty_i;
  logic [15:0] data_i;
  logic        rd_en_o;
  logic [15:0] sample_o;
  logic        sample_valid_o;
  logic        clr_underrun_i = 1'b0;
  logic        underrun_o;
  logic [7:0]  underrun_cnt_o;

  fifo_sample_reader #(.DATA_WIDTH(16), .DIV_WIDTH(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .en_low_i       (en_low_i),
    .rate_i         (rate_i),
    .empty_i        (empty_i),
    .data_i         (data_i),
    .rd_en_o        (rd_en_o),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .clr_underrun_i (clr_underrun_i),
    .underrun_o     (underrun_o),
    .underrun_cnt_o (underrun_cnt_o)
  );

  always #5 clk = ~clk;

  // FIFO model: first-word-fall-through is not assumed; data appears one clock after the pop.
  logic [15:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign empty_i = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (rd_en_o) begin
      data_i <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  int cyc = 0;
  int rd_count = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en_o) rd_count <= rd_count + 1;
  end

  int checks = 0;
  int fails  = 0;
  int prev_cyc = 0;
  int rd_prev  = 0;

  typedef struct {
    logic [15:0] smp;
    logic        ur;
    logic [7:0]  ucnt;
    int          intv;
    int          rds;
  } vec_t;

  vec_t vecs [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic wait_valid(input string name, input int limit);
    bit got;
    got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      tick();
      got = sample_valid_o;
    end
    if (!got) begin
      checks++;
      fails++;
      $display("FAIL %s: sample_valid_o still 0 after %0d cycles, required 1", name, limit);
    end
  endtask

  task automatic wait_rd(input string name, input int limit);
    bit got;
    got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      tick();
      got = rd_en_o;
    end
    if (!got) begin
      checks++;
      fails++;
      $display("FAIL %s: rd_en_o still 0 after %0d cycles, required 1", name, limit);
    end
  endtask

  task automatic check_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    wait_valid($sformatf("vec%0d_valid", idx), 40);
    $display("vec%0d: sample=0x%0h ur=%0b ucnt=%0d intv=%0d rds=%0d", idx, sample_o,
             underrun_o, underrun_cnt_o, cyc - prev_cyc, rd_count - rd_prev);
    check($sformatf("vec%0d_sample", idx), 32'(sample_o), 32'(v.smp));
    check($sformatf("vec%0d_underrun", idx), 32'(underrun_o), 32'(v.ur));
    check($sformatf("vec%0d_ucnt", idx), 32'(underrun_cnt_o), 32'(v.ucnt));
    check($sformatf("vec%0d_interval", idx), 32'(cyc - prev_cyc), 32'(v.intv));
    check($sformatf("vec%0d_reads", idx), 32'(rd_count - rd_prev), 32'(v.rds));
    prev_cyc = cyc;
    rd_prev  = rd_count;
  endtask

  initial begin
    int bad;
    int rd_snap;

    vecs[0]  = '{16'h0010, 1'b0, 8'd0, 7, 1};
    vecs[1]  = '{16'h0020, 1'b0, 8'd0, 4, 1};
    vecs[2]  = '{16'h0030, 1'b0, 8'd0, 4, 1};
    vecs[3]  = '{16'h0030, 1'b1, 8'd1, 2, 0};
    vecs[4]  = '{16'h0030, 1'b1, 8'd2, 4, 0};
    vecs[5]  = '{16'h0050, 1'b1, 8'd1, 6, 1};
    vecs[6]  = '{16'h0061, 1'b1, 8'd1, 3, 1};
    vecs[7]  = '{16'h0062, 1'b1, 8'd1, 3, 1};
    vecs[8]  = '{16'h0063, 1'b1, 8'd1, 3, 1};
    vecs[9]  = '{16'h0064, 1'b1, 8'd1, 3, 1};
    vecs[10] = '{16'h0065, 1'b1, 8'd1, 3, 1};
    vecs[11] = '{16'h0071, 1'b1, 8'd2, 13, 1};
    vecs[12] = '{16'h0072, 1'b1, 8'd2, 10, 1};
    vecs[13] = '{16'h0073, 1'b1, 8'd2, 10, 1};

    // Reset state
    repeat (3) tick();
    check("rst_sample", 32'(sample_o), 32'h0);
    check("rst_valid", 32'(sample_valid_o), 32'h0);
    check("rst_rd_en", 32'(rd_en_o), 32'h0);
    check("rst_underrun", 32'(underrun_o), 32'h0);
    check("rst_ucnt", 32'(underrun_cnt_o), 32'h0);

    // Three samples at rate 4, then two underruns
    push(16'h0010);
    push(16'h0020);
    push(16'h0030);
    rst      = 1'b1;
    en_low_i = 1'b0;
    prev_cyc = cyc;
    rd_prev  = rd_count;
    for (int i = 0; i <= 4; i++) check_vec(i);

    // Saturate the underrun counter
    rd_snap = rd_count;
    repeat (1250) tick();
    check("sat_ucnt", 32'(underrun_cnt_o), 32'd255);
    check("sat_underrun", 32'(underrun_o), 32'h1);
    check("sat_no_reads", 32'(rd_count), 32'(rd_snap));

    // Clear coincident with an underrun tick (tick is 3 clocks after the underrun pulse)
    wait_valid("clr_sync", 10);
    repeat (3) tick();
    clr_underrun_i = 1'b1;
    tick();
    clr_underrun_i = 1'b0;
    check("clr_valid", 32'(sample_valid_o), 32'h1);
    check("clr_underrun", 32'(underrun_o), 32'h0);
    check("clr_ucnt", 32'(underrun_cnt_o), 32'h0);
    wait_valid("after_clr", 10);
    check("after_clr_ucnt", 32'(underrun_cnt_o), 32'd1);

    // Disable during READ: capture completes, then idle
    push(16'h0040);
    wait_rd("dis_rd", 10);
    en_low_i = 1'b1;
    tick();
    check("dis_capture_rd_en", 32'(rd_en_o), 32'h0);
    check("dis_capture_valid", 32'(sample_valid_o), 32'h0);
    tick();
    check("dis_valid", 32'(sample_valid_o), 32'h1);
    check("dis_sample", 32'(sample_o), 32'h0040);
    push(16'h0050);
    rd_snap = rd_count;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rd_en_o || sample_valid_o) bad++;
    end
    check("idle_quiet_cycles", 32'(bad), 32'h0);
    check("idle_no_reads", 32'(rd_count), 32'(rd_snap));
    check("idle_sample_held", 32'(sample_o), 32'h0040);

    // rate 1 latches as 3; change to 10 while running is ignored
    rate_i = 16'd1;
    for (int i = 1; i <= 5; i++) push(16'(16'h0060 + i));
    prev_cyc = cyc;
    rd_prev  = rd_count;
    en_low_i = 1'b0;
    tick();
    rate_i = 16'd10;
    for (int i = 5; i <= 10; i++) check_vec(i);
    tick();
    check("tail_underrun_valid", 32'(sample_valid_o), 32'h1);
    check("tail_ucnt", 32'(underrun_cnt_o), 32'd2);
    check("tail_sample_held", 32'(sample_o), 32'h0065);
    en_low_i = 1'b1;
    repeat (4) tick();

    // New period takes effect on the next exit from idle
    push(16'h0071);
    push(16'h0072);
    push(16'h0073);
    prev_cyc = cyc;
    rd_prev  = rd_count;
    en_low_i = 1'b0;
    for (int i = 11; i <= 13; i++) check_vec(i);

    // Asynchronous reset in the middle of CAPTURE
    push(16'h0080);
    wait_rd("rst_rd", 20);
    tick();
    rst = 1'b0;
    #1;
    check("arst_sample", 32'(sample_o), 32'h0);
    check("arst_valid", 32'(sample_valid_o), 32'h0);
    check("arst_rd_en", 32'(rd_en_o), 32'h0);
    check("arst_underrun", 32'(underrun_o), 32'h0);
    check("arst_ucnt", 32'(underrun_cnt_o), 32'h0);
    en_low_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (sample_valid_o || rd_en_o) bad++;
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (sample_valid_o || rd_en_o) bad++;
    end
    check("arst_no_pulse", 32'(bad), 32'h0);
    check("arst_sample_after", 32'(sample_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
